// File: rtl/global_pkg.sv
// Shared core types: memory operation encoding and memory bus arbiter state/owner.
package global_pkg;

   typedef enum logic [1:0] {
      MEM_NONE   = 2'b00,
      LOAD_DATA  = 2'b01,
      STORE_DATA = 2'b10
   } memory_operation_t;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      CMD       = 2'b01,
      WAIT_DATA = 2'b10
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_LSU   = 1'b1
   } arb_owner_t;

   // Fetches are always full 32-bit words.
   localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and the load/store
// unit. Round-robin arbitration, registered command, combinational ack/data
// return to the owner, and a watchdog that force-completes a stalled load.
module mem_bus_arbiter
   import global_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              f_cyc,
   input  logic [31:0]       f_addr,
   output logic              f_ack,
   output logic              f_data_valid,
   output logic [31:0]       f_rdata,

   input  logic              l_cyc,
   input  memory_operation_t l_op,
   input  logic [2:0]        l_funct3,
   input  logic [31:0]       l_addr,
   input  logic [31:0]       l_wdata,
   output logic              l_ack,
   output logic              l_data_valid,
   output logic [31:0]       l_rdata,

   output logic              m_cyc,
   output memory_operation_t m_op,
   output logic [2:0]        m_funct3,
   output logic [31:0]       m_addr,
   output logic [31:0]       m_wdata,
   input  logic              m_ack,
   input  logic              m_data_valid,
   input  logic [31:0]       m_rdata,

   output logic              bus_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state, state_nxt;
   arb_owner_t        owner, owner_nxt;
   arb_owner_t        last, last_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   memory_operation_t op_nxt;
   logic [2:0]        funct3_nxt;
   logic [31:0]       addr_nxt;
   logic [31:0]       wdata_nxt;
   logic              grant_lsu;
   logic              ret_valid;
   logic [31:0]       ret_data;

   // State, ownership, watchdog and bus command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= OWN_FETCH;
         last     <= OWN_FETCH;
         cnt      <= '0;
         m_op     <= MEM_NONE;
         m_funct3 <= 3'b000;
         m_addr   <= 32'h0;
         m_wdata  <= 32'h0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         cnt      <= cnt_nxt;
         m_op     <= op_nxt;
         m_funct3 <= funct3_nxt;
         m_addr   <= addr_nxt;
         m_wdata  <= wdata_nxt;
      end
   end

   // LSU wins when it is the only requester, or on a tie when fetch was granted last.
   assign grant_lsu = l_cyc && (!f_cyc || (last == OWN_FETCH));

   // Next-state, command latch and owner-routed return path.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last;
      cnt_nxt      = cnt;
      op_nxt       = m_op;
      funct3_nxt   = m_funct3;
      addr_nxt     = m_addr;
      wdata_nxt    = m_wdata;
      m_cyc        = 1'b0;
      bus_err      = 1'b0;
      f_ack        = 1'b0;
      l_ack        = 1'b0;
      ret_valid    = 1'b0;
      ret_data     = 32'h0;

      case (state)
         IDLE: begin
            if (f_cyc || l_cyc) begin
               state_nxt = CMD;
               if (grant_lsu) begin
                  owner_nxt  = OWN_LSU;
                  last_nxt   = OWN_LSU;
                  op_nxt     = l_op;
                  funct3_nxt = l_funct3;
                  addr_nxt   = l_addr;
                  wdata_nxt  = l_wdata;
               end else begin
                  owner_nxt  = OWN_FETCH;
                  last_nxt   = OWN_FETCH;
                  op_nxt     = LOAD_DATA;
                  funct3_nxt = FUNCT3_WORD;
                  addr_nxt   = f_addr;
                  wdata_nxt  = 32'h0;
               end
            end
         end

         CMD: begin
            m_cyc = 1'b1;
            if (owner == OWN_FETCH) f_ack = m_ack;
            else                    l_ack = m_ack;
            if (m_ack) begin
               if (m_op == STORE_DATA) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT_DATA;
                  cnt_nxt   = '0;
               end
            end
         end

         WAIT_DATA: begin
            if (m_data_valid) begin
               ret_valid = 1'b1;
               ret_data  = m_rdata;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               ret_valid = 1'b1;
               ret_data  = ERR_DATA;
               bus_err   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Only the owner sees the data phase; the other side reads zero.
   always_comb begin
      f_data_valid = 1'b0;
      f_rdata      = 32'h0;
      l_data_valid = 1'b0;
      l_rdata      = 32'h0;
      if (owner == OWN_FETCH) begin
         f_data_valid = ret_valid;
         f_rdata      = ret_data;
      end else begin
         l_data_valid = ret_valid;
         l_rdata      = ret_data;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
   import global_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              f_cyc;
   logic [31:0]       f_addr;
   logic              f_ack, f_data_valid;
   logic [31:0]       f_rdata;
   logic              l_cyc;
   memory_operation_t l_op;
   logic [2:0]        l_funct3;
   logic [31:0]       l_addr, l_wdata;
   logic              l_ack, l_data_valid;
   logic [31:0]       l_rdata;
   logic              m_cyc;
   memory_operation_t m_op;
   logic [2:0]        m_funct3;
   logic [31:0]       m_addr, m_wdata;
   logic              m_ack, m_data_valid;
   logic [31:0]       m_rdata;
   logic              bus_err;

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter #(.TIMEOUT(64), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst),
      .f_cyc(f_cyc), .f_addr(f_addr), .f_ack(f_ack),
      .f_data_valid(f_data_valid), .f_rdata(f_rdata),
      .l_cyc(l_cyc), .l_op(l_op), .l_funct3(l_funct3), .l_addr(l_addr),
      .l_wdata(l_wdata), .l_ack(l_ack), .l_data_valid(l_data_valid),
      .l_rdata(l_rdata),
      .m_cyc(m_cyc), .m_op(m_op), .m_funct3(m_funct3), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_ack(m_ack), .m_data_valid(m_data_valid),
      .m_rdata(m_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      f_cyc = 1'b0; f_addr = 32'h0;
      l_cyc = 1'b0; l_op = MEM_NONE; l_funct3 = 3'b000; l_addr = 32'h0; l_wdata = 32'h0;
      m_ack = 1'b0; m_data_valid = 1'b0; m_rdata = 32'h0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({m_cyc, bus_err, f_ack, l_ack, f_data_valid, l_data_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=000000",
                  {m_cyc, bus_err, f_ack, l_ack, f_data_valid, l_data_valid});
      end
      checks++;
      if (m_op !== MEM_NONE || m_addr !== 32'h0 || m_wdata !== 32'h0 || m_funct3 !== 3'b000) begin
         failures++;
         $display("FAIL reset_cmd op=%0d addr=%h wdata=%h f3=%b want 0", m_op, m_addr, m_wdata, m_funct3);
      end
   endtask

   task automatic test_lone_fetch();
      f_cyc = 1'b1; f_addr = 32'h100;
      #1;
      checks++;
      if (m_cyc !== 1'b0) begin failures++; $display("FAIL fetch_no_early_cyc got=%b want=0", m_cyc); end
      step();
      f_cyc = 1'b0;
      #1;
      checks++;
      if (m_cyc !== 1'b1 || m_op !== LOAD_DATA || m_funct3 !== 3'b010 || m_addr !== 32'h100 || m_wdata !== 32'h0) begin
         failures++;
         $display("FAIL fetch_cmd cyc=%b op=%0d f3=%b addr=%h wdata=%h want 1/1/010/100/0",
                  m_cyc, m_op, m_funct3, m_addr, m_wdata);
      end
      checks++;
      if (f_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_before got=%b want=0", f_ack); end
      m_ack = 1'b1;
      #1;
      checks++;
      if (f_ack !== 1'b1 || l_ack !== 1'b0) begin
         failures++; $display("FAIL fetch_ack f_ack=%b l_ack=%b want 1/0", f_ack, l_ack);
      end
      step();
      m_ack = 1'b0;
      step();
      step();
      #1;
      checks++;
      if (m_cyc !== 1'b0 || f_data_valid !== 1'b0) begin
         failures++; $display("FAIL fetch_wait cyc=%b dv=%b want 0/0", m_cyc, f_data_valid);
      end
      m_data_valid = 1'b1; m_rdata = 32'h00000013;
      #1;
      checks++;
      if (f_data_valid !== 1'b1 || f_rdata !== 32'h13 || l_data_valid !== 1'b0 || l_rdata !== 32'h0) begin
         failures++;
         $display("FAIL fetch_data f_dv=%b f_rdata=%h l_dv=%b l_rdata=%h want 1/13/0/0",
                  f_data_valid, f_rdata, l_data_valid, l_rdata);
      end
      step();
      m_data_valid = 1'b0;
      #1;
      checks++;
      if (f_data_valid !== 1'b0 || m_cyc !== 1'b0) begin
         failures++; $display("FAIL fetch_done dv=%b cyc=%b want 0/0", f_data_valid, m_cyc);
      end
   endtask

   task automatic test_store();
      l_cyc = 1'b1; l_op = STORE_DATA; l_funct3 = 3'b010; l_addr = 32'h2000; l_wdata = 32'hCAFEF00D;
      step();
      l_cyc = 1'b0; l_op = MEM_NONE; l_wdata = 32'h0;
      #1;
      checks++;
      if (m_cyc !== 1'b1 || m_op !== STORE_DATA || m_addr !== 32'h2000 || m_wdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL store_cmd cyc=%b op=%0d addr=%h wdata=%h want 1/2/2000/cafef00d",
                  m_cyc, m_op, m_addr, m_wdata);
      end
      step();
      checks++;
      if (m_cyc !== 1'b1 || l_ack !== 1'b0) begin
         failures++; $display("FAIL store_hold cyc=%b l_ack=%b want 1/0", m_cyc, l_ack);
      end
      m_ack = 1'b1;
      #1;
      checks++;
      if (l_ack !== 1'b1 || f_ack !== 1'b0) begin
         failures++; $display("FAIL store_ack l_ack=%b f_ack=%b want 1/0", l_ack, f_ack);
      end
      step();
      m_ack = 1'b0;
      #1;
      checks++;
      if (m_cyc !== 1'b0 || l_data_valid !== 1'b0) begin
         failures++; $display("FAIL store_idle cyc=%b dv=%b want 0/0", m_cyc, l_data_valid);
      end
      m_data_valid = 1'b1;
      #1;
      checks++;
      if (l_data_valid !== 1'b0 || f_data_valid !== 1'b0) begin
         failures++; $display("FAIL store_no_data l_dv=%b f_dv=%b want 0/0", l_data_valid, f_data_valid);
      end
      step();
      m_data_valid = 1'b0;
   endtask

   task automatic test_tie();
      logic [31:0] exp_addr [4];
      int n;
      exp_addr[0] = 32'h800; exp_addr[1] = 32'h400; exp_addr[2] = 32'h800; exp_addr[3] = 32'h400;
      do_reset();
      f_cyc = 1'b1; f_addr = 32'h400;
      l_cyc = 1'b1; l_op = STORE_DATA; l_funct3 = 3'b001; l_addr = 32'h800; l_wdata = 32'h1234;
      n = 0;
      for (int g = 0; g < 4; g++) begin
         while (!m_cyc && n < 10) begin step(); n++; end
         checks++;
         if (n !== ((g == 0) ? 1 : 2)) begin
            failures++; $display("FAIL tie_gap%0d cycles=%0d want=%0d", g, n, (g == 0) ? 1 : 2);
         end
         checks++;
         if (m_addr !== exp_addr[g]) begin
            failures++; $display("FAIL tie_grant%0d addr=%h want=%h", g, m_addr, exp_addr[g]);
         end
         m_ack = 1'b1;
         #1;
         if (exp_addr[g] == 32'h800) begin
            checks++;
            if (l_ack !== 1'b1 || f_ack !== 1'b0) begin
               failures++; $display("FAIL tie_ack%0d l_ack=%b f_ack=%b want 1/0", g, l_ack, f_ack);
            end
         end else begin
            checks++;
            if (f_ack !== 1'b1 || l_ack !== 1'b0) begin
               failures++; $display("FAIL tie_ack%0d f_ack=%b l_ack=%b want 1/0", g, f_ack, l_ack);
            end
            step();
            m_ack = 1'b0; m_data_valid = 1'b1; m_rdata = 32'hA0 + 32'(g);
            #1;
            checks++;
            if (f_data_valid !== 1'b1 || f_rdata !== 32'hA0 + 32'(g)) begin
               failures++; $display("FAIL tie_data%0d dv=%b rdata=%h want 1/%h", g, f_data_valid, f_rdata, 32'hA0 + 32'(g));
            end
         end
         step();
         m_ack = 1'b0; m_data_valid = 1'b0;
         n = 1;
      end
      f_cyc = 1'b0; l_cyc = 1'b0;
   endtask

   task automatic test_timeout();
      int early;
      do_reset();
      l_cyc = 1'b1; l_op = LOAD_DATA; l_funct3 = 3'b100; l_addr = 32'h3000;
      step();
      l_cyc = 1'b0;
      m_ack = 1'b1;
      #1;
      checks++;
      if (l_ack !== 1'b1 || m_op !== LOAD_DATA || m_funct3 !== 3'b100) begin
         failures++; $display("FAIL to_ack l_ack=%b op=%0d f3=%b want 1/1/100", l_ack, m_op, m_funct3);
      end
      step();
      m_ack = 1'b0;
      early = 0;
      for (int k = 1; k < 64; k++) begin
         #1;
         if (l_data_valid !== 1'b0 || bus_err !== 1'b0 || m_cyc !== 1'b0) early++;
         step();
      end
      checks++;
      if (early !== 0) begin failures++; $display("FAIL to_early count=%0d want=0", early); end
      #1;
      checks++;
      if (l_data_valid !== 1'b1 || l_rdata !== 32'hDEADBEEF || bus_err !== 1'b1 || f_data_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_fire dv=%b rdata=%h err=%b f_dv=%b want 1/deadbeef/1/0",
                  l_data_valid, l_rdata, bus_err, f_data_valid);
      end
      step();
      checks++;
      if (bus_err !== 1'b0 || l_data_valid !== 1'b0 || m_cyc !== 1'b0) begin
         failures++; $display("FAIL to_after err=%b dv=%b cyc=%b want 0/0/0", bus_err, l_data_valid, m_cyc);
      end
      // Next request is served; data arriving with the ack is dropped.
      f_cyc = 1'b1; f_addr = 32'h104;
      step();
      f_cyc = 1'b0;
      m_ack = 1'b1; m_data_valid = 1'b1; m_rdata = 32'h99;
      #1;
      checks++;
      if (m_addr !== 32'h104 || f_ack !== 1'b1 || f_data_valid !== 1'b0) begin
         failures++; $display("FAIL to_next_cmd addr=%h ack=%b dv=%b want 104/1/0", m_addr, f_ack, f_data_valid);
      end
      step();
      m_ack = 1'b0; m_data_valid = 1'b0;
      step();
      m_data_valid = 1'b1; m_rdata = 32'h55;
      #1;
      checks++;
      if (f_data_valid !== 1'b1 || f_rdata !== 32'h55 || bus_err !== 1'b0) begin
         failures++; $display("FAIL to_next_data dv=%b rdata=%h err=%b want 1/55/0", f_data_valid, f_rdata, bus_err);
      end
      step();
      m_data_valid = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      l_cyc = 1'b1; l_op = LOAD_DATA; l_funct3 = 3'b010; l_addr = 32'h4000; l_wdata = 32'h5;
      step();
      l_cyc = 1'b0;
      m_ack = 1'b1;
      step();
      m_ack = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (m_cyc !== 1'b0 || m_op !== MEM_NONE || m_addr !== 32'h0 || m_wdata !== 32'h0 || m_funct3 !== 3'b000) begin
         failures++;
         $display("FAIL rst_mid cyc=%b op=%0d addr=%h wdata=%h f3=%b want all 0",
                  m_cyc, m_op, m_addr, m_wdata, m_funct3);
      end
      m_data_valid = 1'b1; m_rdata = 32'h77;
      #1;
      checks++;
      if (l_data_valid !== 1'b0 || f_data_valid !== 1'b0 || l_rdata !== 32'h0 || bus_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_stray l_dv=%b f_dv=%b l_rdata=%h err=%b want 0/0/0/0",
                  l_data_valid, f_data_valid, l_rdata, bus_err);
      end
      step();
      m_data_valid = 1'b0;
      checks++;
      if (m_cyc !== 1'b0) begin failures++; $display("FAIL rst_stay_idle cyc=%b want=0", m_cyc); end
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_store();
      test_tie();
      test_timeout();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
